// File: rtl/apb_master_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_master_bridge : APB master with slave decode, wait-state timeout, B2B.
// Revision: 1.0
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 2,
  parameter int NUM_SLV = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      transfer,
  input  logic                      mpwrite,
  input  logic [ADDR_W-1:0]         apb_write_paddr,
  input  logic [DATA_W-1:0]         apb_write_data,
  input  logic [ADDR_W-1:0]         apb_read_paddr,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W-1:0]         apb_read_data_out,
  output logic                      done,
  output logic                      err,
  output logic                      busy
);

  localparam logic [SEL_W:0] NUM_SLV_C = NUM_SLV[SEL_W:0];
  localparam logic [7:0]     TIMEOUT_C = TIMEOUT[7:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [ADDR_W-1:0]   w_new_addr;
  logic [SEL_W:0]      w_new_idx;
  logic [SEL_W:0]      w_cur_idx;
  logic                w_cur_valid;
  logic [NUM_SLV-1:0]  w_new_psel;
  logic                w_sel_rdy;
  logic                w_sel_err;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_accept;

  assign w_new_addr  = mpwrite ? apb_write_paddr : apb_read_paddr;
  assign w_new_idx   = {1'b0, w_new_addr[ADDR_W-1 -: SEL_W]};
  assign w_cur_idx   = {1'b0, paddr_q[ADDR_W-1 -: SEL_W]};
  assign w_cur_valid = (w_cur_idx < NUM_SLV_C);

  // Out-of-range indices match no slave, so psel stays zero and rdy/err read as 0.
  always_comb begin
    w_sel_rdy   = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    w_new_psel  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_cur_idx == i[SEL_W:0]) begin
        w_sel_rdy   = pready[i];
        w_sel_err   = pslverr[i];
        w_sel_rdata = prdata[i*DATA_W +: DATA_W];
      end
      w_new_psel[i] = (w_new_idx == i[SEL_W:0]);
    end
  end

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    w_accept  = 1'b0;

    case (state_q)
      IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        w_accept  = transfer;
      end
      SETUP: begin
        if (!w_cur_valid) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          psel_d  = '0;
          state_d = IDLE;
        end else begin
          penable_d = 1'b1;
          cnt_d     = 8'd0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (w_sel_rdy) begin
          done_d = 1'b1;
          err_d  = w_sel_err;
          if (!pwrite_q && !w_sel_err) begin
            rdata_d = w_sel_rdata;
          end
          w_accept  = transfer;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
          // Timeout abort: no back-to-back acceptance in this cycle.
          done_d    = 1'b1;
          err_d     = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    if (w_accept) begin
      state_d   = SETUP;
      pwrite_d  = mpwrite;
      paddr_d   = w_new_addr;
      psel_d    = w_new_psel;
      penable_d = 1'b0;
      if (mpwrite) begin
        pwdata_d = apb_write_data;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q   <= IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign psel              = psel_q;
  assign penable           = penable_q;
  assign paddr             = paddr_q;
  assign pwrite            = pwrite_q;
  assign pwdata            = pwdata_q;
  assign apb_read_data_out = rdata_q;
  assign done              = done_q;
  assign err               = err_q;
  assign busy              = (state_q != IDLE);

endmodule
`default_nettype wire
